// File: rtl/cluster_pkg.sv
// Shared cluster definitions: field widths, frame record, stream word packing.
package cluster_pkg;

  localparam int MXADRBITS  = 11;
  localparam int MXCNTBITS  = 3;
  localparam int MXCLUSTERS = 8;
  localparam int BXNBITS    = 10;
  localparam int NCLBITS    = 4;
  localparam int WORD_W     = 16;

  localparam logic [MXADRBITS-1:0] INVALID_ADR = 11'h7FF;

  // Type codes in the top bits of each stream word
  localparam logic [1:0] HDR_CODE = 2'b10;
  localparam logic       CLU_CODE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HEADER   = 2'd1,
    ST_CLUSTERS = 2'd2
  } ser_state_t;

  // One buffered bunch-crossing frame; entries at and above ncl are unused.
  typedef struct packed {
    logic [BXNBITS-1:0]                      bxn;
    logic [NCLBITS-1:0]                      ncl;
    logic [MXCLUSTERS-1:0][MXADRBITS-1:0]    adr;
    logic [MXCLUSTERS-1:0][MXCNTBITS-1:0]    cnt;
  } frame_t;

  function automatic logic [WORD_W-1:0] pack_header(input logic [BXNBITS-1:0] bxn,
                                                    input logic [NCLBITS-1:0] ncl);
    return {HDR_CODE, bxn, ncl};
  endfunction

  function automatic logic [WORD_W-1:0] pack_cluster(input logic                 last,
                                                     input logic [MXCNTBITS-1:0] cnt,
                                                     input logic [MXADRBITS-1:0] adr);
    return {CLU_CODE, last, cnt, adr};
  endfunction

endpackage

// File: rtl/cluster_frame_buffer.sv
// Whole-frame FIFO: one entry per bunch crossing, head entry presented combinationally.
module cluster_frame_buffer
  import cluster_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   wr_en_i,
  input  frame_t wr_data_i,
  input  logic   rd_en_i,
  output frame_t rd_data_o,
  output logic   full_o,
  output logic   empty_o,
  output logic   single_o
);

  localparam int AW = $clog2(DEPTH);

  frame_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally since DEPTH is a power of 2
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en_i) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_en_i, rd_en_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state register; a reset discards every buffered frame
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Frame storage; when full, a write lands in the slot being popped the same cycle
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign single_o  = (count_q == (AW+1)'(1));

endmodule

// File: rtl/cluster_frame_serializer.sv
// Captures sorted cluster frames, tags them with a BX number, buffers them and
// streams header + per-cluster words on a 16-bit valid/ready interface.
module cluster_frame_serializer
  import cluster_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clock4x,
  input  logic                            reset_n,
  input  logic                            in_valid,
  input  logic [MXCLUSTERS*MXADRBITS-1:0] adr_in,
  input  logic [MXCLUSTERS*MXCNTBITS-1:0] cnt_in,
  input  logic                            bc0,
  output logic [WORD_W-1:0]               out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic [7:0]                      overflow_cnt
);

  ser_state_t          state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [BXNBITS-1:0]  bx_q, bx_d;
  logic [7:0]          ovf_q, ovf_d;
  logic [NCLBITS-1:0]  ncl_c;
  logic [BXNBITS-1:0]  tag_c;
  frame_t              cap_c;
  frame_t              head;
  logic                full, empty, single;
  logic                push, pop_c;
  logic                last_c;

  // Count occupied slots; sorted input puts all valid clusters at the low indices
  always_comb begin
    ncl_c = '0;
    for (int i = 0; i < MXCLUSTERS; i++) begin
      if (adr_in[i*MXADRBITS +: MXADRBITS] != INVALID_ADR) ncl_c = ncl_c + 1'b1;
    end
  end

  // bc0 on the same cycle as a strobe tags that frame with 0
  assign tag_c     = bc0 ? '0 : bx_q;
  assign cap_c.bxn = tag_c;
  assign cap_c.ncl = ncl_c;
  assign cap_c.adr = adr_in;
  assign cap_c.cnt = cnt_in;

  // A full buffer still accepts a frame when the head frame retires this cycle
  assign push = in_valid & (~full | pop_c);

  cluster_frame_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk_i     (clock4x),
    .rst_ni    (reset_n),
    .wr_en_i   (push),
    .wr_data_i (cap_c),
    .rd_en_i   (pop_c),
    .rd_data_o (head),
    .full_o    (full),
    .empty_o   (empty),
    .single_o  (single)
  );

  // BX counter and saturating drop counter next-state
  always_comb begin
    bx_d  = bx_q;
    ovf_d = ovf_q;
    if (in_valid)  bx_d = tag_c + 1'b1;
    else if (bc0)  bx_d = '0;
    if (in_valid && !push && (ovf_q != 8'hFF)) ovf_d = ovf_q + 1'b1;
  end

  // Output FSM: next state, pop strobe and combinational stream word from the head frame.
  // After a pop the buffer stays non-empty if more than one frame was held or a frame
  // arrives now (buffer cannot be full when it holds one frame), so no bubble is inserted.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pop_c     = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    last_c    = ({1'b0, idx_q} == (head.ncl - 4'd1));
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          state_d = ST_HEADER;
          idx_d   = '0;
        end
      end
      ST_HEADER: begin
        out_valid = 1'b1;
        out_data  = pack_header(head.bxn, head.ncl);
        out_last  = (head.ncl == '0);
        if (out_ready) begin
          idx_d = '0;
          if (head.ncl == '0) begin
            pop_c   = 1'b1;
            state_d = (!single || in_valid) ? ST_HEADER : ST_IDLE;
          end else begin
            state_d = ST_CLUSTERS;
          end
        end
      end
      ST_CLUSTERS: begin
        out_valid = 1'b1;
        out_data  = pack_cluster(last_c, head.cnt[idx_q], head.adr[idx_q]);
        out_last  = last_c;
        if (out_ready) begin
          if (last_c) begin
            pop_c   = 1'b1;
            idx_d   = '0;
            state_d = (!single || in_valid) ? ST_HEADER : ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      bx_q    <= '0;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bx_q    <= bx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_cluster_frame_serializer.sv
// Bench for cluster_frame_serializer: scoreboard of expected stream words plus directed corners.
module tb_cluster_frame_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [87:0] adr_in;
  logic [23:0] cnt_in;
  logic        bc0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [7:0]  overflow_cnt;

  cluster_frame_serializer dut (
    .clock4x      (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .adr_in       (adr_in),
    .cnt_in       (cnt_in),
    .bc0          (bc0),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .overflow_cnt (overflow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [87:0] adr;
    logic [23:0] cnt;
    int          ncl;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[4];
  int          total = 0;
  int          bad   = 0;
  logic [9:0]  bx_m  = '0;
  logic [87:0] all_inv;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic push_frame(input logic [87:0] a, input logic [23:0] c,
                            input logic [9:0] tag, input int n);
    logic [3:0] n4;
    n4 = 4'(n);
    push_exp({2'b10, tag, n4}, (n == 0));
    for (int i = 0; i < n; i++)
      push_exp({1'b0, (i == n - 1), c[i*3 +: 3], a[i*11 +: 11]}, (i == n - 1));
  endtask

  // One strobe, then three idle cycles (4-clock spacing)
  task automatic send_frame(input logic [87:0] a, input logic [23:0] c, input logic b0,
                            input bit keep, input int n);
    logic [9:0] tag;
    @(posedge clk); #1;
    in_valid = 1'b1;
    adr_in   = a;
    cnt_in   = c;
    bc0      = b0;
    tag      = b0 ? 10'd0 : bx_m;
    bx_m     = tag + 10'd1;
    if (keep) push_frame(a, c, tag, n);
    @(posedge clk); #1;
    in_valid = 1'b0;
    bc0      = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || out_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending_words", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    sb.delete();
    bx_m = '0;
  endtask

  // Scoreboard: every accepted word must match the next expected word in order
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got=%h last=%b want=none", out_data, out_last);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          bad++;
          $display("FAIL sb_word got=%h last=%b want=%h last=%b", out_data, out_last, e.data, e.last);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int hs, n;
    logic [15:0] held_d;
    logic        held_l;

    all_inv = {8{11'h7FF}};
    tbl[0] = '{adr: {11'd1400, 11'd1200, 11'd1000, 11'd800, 11'd600, 11'd400, 11'd200, 11'd0},
               cnt: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, ncl: 8};
    tbl[1] = '{adr: {{7{11'h7FF}}, 11'h7FE},
               cnt: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5}, ncl: 1};
    tbl[2] = '{adr: {{3{11'h7FF}}, 11'd900, 11'd512, 11'd300, 11'd17, 11'd3},
               cnt: {3'd0, 3'd0, 3'd0, 3'd5, 3'd3, 3'd6, 3'd2, 3'd7}, ncl: 5};
    tbl[3] = '{adr: {8{11'h7FF}}, cnt: 24'hFFFFFF, ncl: 0};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    adr_in    = '0;
    cnt_in    = '0;
    bc0       = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_overflow", overflow_cnt, 0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Empty frame: single header word, two cycles after the strobe
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    adr_in   = all_inv;
    cnt_in   = '0;
    push_exp(16'h8000, 1'b1);
    bx_m = 10'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_t1_valid", out_valid, 0);
    @(negedge clk);
    check("lat_t2_valid", out_valid, 1);
    check("lat_t2_data", out_data, 16'h8000);
    check("lat_t2_last", out_last, 1);
    wait_drain(50);

    // Three-cluster frame with fixed expected words
    push_exp(16'h8013, 1'b0);
    push_exp(16'h0005, 1'b0);
    push_exp(16'h080C, 1'b0);
    push_exp(16'h501E, 1'b1);
    send_frame({{5{11'h7FF}}, 11'd30, 11'd12, 11'd5},
               {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1, 3'd0}, 1'b0, 1'b0, 3);
    wait_drain(50);

    // Table vectors back to back
    for (int i = 0; i < 4; i++)
      send_frame(tbl[i].adr, tbl[i].cnt, 1'b0, 1'b1, tbl[i].ncl);
    wait_drain(300);

    // Stall mid-frame for 10 cycles
    out_ready = 1'b0;
    send_frame(tbl[0].adr, tbl[0].cnt, 1'b0, 1'b1, 8);
    @(posedge clk); #1 out_ready = 1'b1;
    hs = 0;
    n  = 0;
    while (hs < 3 && n < 50) begin
      @(negedge clk);
      n++;
      if (out_valid && out_ready) hs++;
    end
    check("stall_handshakes", hs, 3);
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    held_d = out_data;
    held_l = out_last;
    check("stall_valid", out_valid, 1);
    check("stall_word", held_d, 16'h1190);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_data_stable", out_data, held_d);
      check("stall_last_stable", out_last, held_l);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(100);

    // Overflow: 6 full frames into a 4-deep stalled buffer
    do_reset();
    out_ready = 1'b0;
    for (int f = 0; f < 6; f++)
      send_frame(tbl[0].adr, tbl[0].cnt, (f == 0), (f < 4), 8);
    @(negedge clk);
    check("ovf_count", overflow_cnt, 2);
    check("ovf_head_word", out_data, 16'h8008);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_drain(200);

    // BX wrap and bc0 alignment
    do_reset();
    out_ready = 1'b1;
    for (int s = 1; s <= 1625; s++)
      send_frame(all_inv, 24'd0, (s == 600), 1'b1, 0);
    wait_drain(50);

    // Reset while emitting clusters
    out_ready = 1'b0;
    push_exp({2'b10, bx_m, 4'd5}, 1'b0);
    send_frame(tbl[2].adr, tbl[2].cnt, 1'b0, 1'b0, 5);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("mid_clusters_valid", out_valid, 1);
    check("mid_clusters_word", out_data, 16'h3803);
    check("mid_header_consumed", sb.size(), 0);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    sb.delete();
    bx_m = '0;
    @(posedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_empty", out_valid, 0);
    out_ready = 1'b1;
    send_frame(tbl[1].adr, tbl[1].cnt, 1'b0, 1'b1, 1);
    wait_drain(50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
